ex_mem_skid: RTL and testbench

- Registered EX->MEM boundary directly downstream of the ALU. Captures the ALU result, zero and over flags, plus the sideband fields that travel with the instruction.
- Classifies execute-stage exceptions: arithmetic overflow, and load/store address misalignment.
- Presents one instruction per cycle to the MEM stage through a valid/ready handshake.
- Contains a 2-entry skid buffer, so the EX-side ready is a pure register output and MEM backpressure never forms a combinational path into EX.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/exc_classify.sv | 70 +++++++
 rtl/ex_mem_skid.sv | 145 ++++++++++++++
 tb/tb_ex_mem_skid.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU pipeline types for the EX->MEM boundary
// Holds memory-op encodings, execute-stage exception codes and the
// ex_mem_t record carried from EX into MEM.
package cpu_pkg;

   localparam int CPU_DW = 32;
   localparam int CPU_RW = 5;

   // Execute-stage exception codes (CP0 Cause.ExcCode values)
   localparam logic [4:0] CPU_EXC_OV   = 5'h0C;
   localparam logic [4:0] CPU_EXC_ADEL = 5'h04;
   localparam logic [4:0] CPU_EXC_ADES = 5'h05;

   typedef enum logic [2:0] {
      MOP_NONE = 3'd0,
      MOP_LB   = 3'd1,
      MOP_LH   = 3'd2,
      MOP_LW   = 3'd3,
      MOP_SB   = 3'd4,
      MOP_SH   = 3'd5,
      MOP_SW   = 3'd6,
      MOP_RSVD = 3'd7
   } mem_op_e;

   typedef struct packed {
      logic [CPU_DW-1:0] result;
      logic              zero;
      logic [CPU_DW-1:0] pc;
      logic              wen;
      logic [CPU_RW-1:0] wreg;
      mem_op_e           mem_op;
      logic [CPU_DW-1:0] sdata;
      logic              exc;
      logic [4:0]        exc_code;
      logic [CPU_DW-1:0] badvaddr;
   } ex_mem_t;

endpackage

// File: rtl/exc_classify.sv
// rtl/exc_classify.sv - combinational execute-stage exception classifier
// Inputs : ALU result/flags and instruction sideband (result_i, over_i,
//          trap_ov_i, zero_i, pc_i, wen_i, wreg_i, mem_op_i, sdata_i)
// Outputs: ent_o, an ex_mem_t with exception fields filled and wen/mem_op
//          squashed when an exception is raised.
module exc_classify
   import cpu_pkg::*;
#(
   parameter logic [4:0] EXC_OV   = CPU_EXC_OV,
   parameter logic [4:0] EXC_ADEL = CPU_EXC_ADEL,
   parameter logic [4:0] EXC_ADES = CPU_EXC_ADES
) (
   input  logic [CPU_DW-1:0] result_i,
   input  logic              over_i,
   input  logic              trap_ov_i,
   input  logic              zero_i,
   input  logic [CPU_DW-1:0] pc_i,
   input  logic              wen_i,
   input  logic [CPU_RW-1:0] wreg_i,
   input  logic [2:0]        mem_op_i,
   input  logic [CPU_DW-1:0] sdata_i,
   output ex_mem_t           ent_o
);

   logic    misal_h;
   logic    misal_w;
   logic    is_adel;
   logic    is_ades;
   mem_op_e op;

   always_comb begin
      // Reserved encoding is carried forward as "no memory access".
      op      = (mem_op_i == MOP_RSVD) ? MOP_NONE : mem_op_e'(mem_op_i);
      misal_h = result_i[0];
      misal_w = |result_i[1:0];
      // Byte ops are never checked: any address is aligned for them.
      is_adel = ((op == MOP_LH) && misal_h) || ((op == MOP_LW) && misal_w);
      is_ades = ((op == MOP_SH) && misal_h) || ((op == MOP_SW) && misal_w);

      ent_o          = '0;
      ent_o.result   = result_i;
      ent_o.zero     = zero_i;
      ent_o.pc       = pc_i;
      ent_o.wen      = wen_i;
      ent_o.wreg     = wreg_i;
      ent_o.mem_op   = op;
      ent_o.sdata    = sdata_i;

      // Priority: overflow trap, then load misalignment, then store.
      if (trap_ov_i && over_i) begin
         ent_o.exc      = 1'b1;
         ent_o.exc_code = EXC_OV;
      end else if (is_adel) begin
         ent_o.exc      = 1'b1;
         ent_o.exc_code = EXC_ADEL;
         ent_o.badvaddr = result_i;
      end else if (is_ades) begin
         ent_o.exc      = 1'b1;
         ent_o.exc_code = EXC_ADES;
         ent_o.badvaddr = result_i;
      end

      // A faulting instruction must not write the register file or memory.
      if (ent_o.exc) begin
         ent_o.wen    = 1'b0;
         ent_o.mem_op = MOP_NONE;
      end
   end

endmodule

// File: rtl/ex_mem_skid.sv
// rtl/ex_mem_skid.sv - registered EX->MEM boundary with 2-entry skid buffer
// EX side : ex_valid/ex_ready handshake plus ALU result, flags and sideband.
// MEM side: mem_valid/mem_ready handshake plus registered copies of the EX
//           fields and the classified exception (mem_exc, code, badvaddr).
// Control : clk, async active-high rst, synchronous flush.
module ex_mem_skid
   import cpu_pkg::*;
#(
   parameter int         DW       = CPU_DW,
   parameter int         RW       = CPU_RW,
   parameter logic [4:0] EXC_OV   = CPU_EXC_OV,
   parameter logic [4:0] EXC_ADEL = CPU_EXC_ADEL,
   parameter logic [4:0] EXC_ADES = CPU_EXC_ADES
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          ex_valid,
   output logic          ex_ready,
   input  logic [DW-1:0] ex_result,
   input  logic          ex_over,
   input  logic          ex_trap_ov,
   input  logic          ex_zero,
   input  logic [DW-1:0] ex_pc,
   input  logic          ex_wen,
   input  logic [RW-1:0] ex_wreg,
   input  logic [2:0]    ex_mem_op,
   input  logic [DW-1:0] ex_sdata,
   output logic          mem_valid,
   input  logic          mem_ready,
   output logic [DW-1:0] mem_result,
   output logic          mem_zero,
   output logic [DW-1:0] mem_pc,
   output logic          mem_wen,
   output logic [RW-1:0] mem_wreg,
   output logic [2:0]    mem_mem_op,
   output logic [DW-1:0] mem_sdata,
   output logic          mem_exc,
   output logic [4:0]    mem_exc_code,
   output logic [DW-1:0] mem_badvaddr
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0] state_q, state_d;
   logic       ex_ready_q, ex_ready_d;
   ex_mem_t    main_q, main_d;
   ex_mem_t    skid_q, skid_d;
   ex_mem_t    in_ent;
   logic       accept;
   logic       drain;

   exc_classify #(
      .EXC_OV   (EXC_OV),
      .EXC_ADEL (EXC_ADEL),
      .EXC_ADES (EXC_ADES)
   ) u_exc_classify (
      .result_i  (ex_result),
      .over_i    (ex_over),
      .trap_ov_i (ex_trap_ov),
      .zero_i    (ex_zero),
      .pc_i      (ex_pc),
      .wen_i     (ex_wen),
      .wreg_i    (ex_wreg),
      .mem_op_i  (ex_mem_op),
      .sdata_i   (ex_sdata),
      .ent_o     (in_ent)
   );

   assign accept = ex_valid && ex_ready_q;
   assign drain  = mem_valid && mem_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      if (flush) begin
         // Squash everything, including a same-cycle accept; stale data
         // is left in place since mem_valid=0 hides it.
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_d  = in_ent;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && drain) begin
                  main_d = in_ent;
               end else if (accept) begin
                  skid_d  = in_ent;
                  state_d = ST_FULL;
               end else if (drain) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // ex_ready is low here, so no accept can arrive.
               if (drain) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end

      // Registered ready: computed from next state so it is valid on the
      // same edge the buffer fills, without any path from mem_ready.
      ex_ready_d = (state_d != ST_FULL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         ex_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         ex_ready_q <= ex_ready_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
      end
   end

   assign ex_ready     = ex_ready_q;
   assign mem_valid    = (state_q != ST_EMPTY);
   assign mem_result   = main_q.result;
   assign mem_zero     = main_q.zero;
   assign mem_pc       = main_q.pc;
   assign mem_wen      = main_q.wen;
   assign mem_wreg     = main_q.wreg;
   assign mem_mem_op   = main_q.mem_op;
   assign mem_sdata    = main_q.sdata;
   assign mem_exc      = main_q.exc;
   assign mem_exc_code = main_q.exc_code;
   assign mem_badvaddr = main_q.badvaddr;

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb/tb_ex_mem_skid.sv - directed self-checking bench for ex_mem_skid
module tb_ex_mem_skid;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_result;
   logic        ex_over;
   logic        ex_trap_ov;
   logic        ex_zero;
   logic [31:0] ex_pc;
   logic        ex_wen;
   logic [4:0]  ex_wreg;
   logic [2:0]  ex_mem_op;
   logic [31:0] ex_sdata;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_result;
   logic        mem_zero;
   logic [31:0] mem_pc;
   logic        mem_wen;
   logic [4:0]  mem_wreg;
   logic [2:0]  mem_mem_op;
   logic [31:0] mem_sdata;
   logic        mem_exc;
   logic [4:0]  mem_exc_code;
   logic [31:0] mem_badvaddr;

   int n_assert = 0;
   int n_fail   = 0;

   ex_mem_skid dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .ex_valid     (ex_valid),
      .ex_ready     (ex_ready),
      .ex_result    (ex_result),
      .ex_over      (ex_over),
      .ex_trap_ov   (ex_trap_ov),
      .ex_zero      (ex_zero),
      .ex_pc        (ex_pc),
      .ex_wen       (ex_wen),
      .ex_wreg      (ex_wreg),
      .ex_mem_op    (ex_mem_op),
      .ex_sdata     (ex_sdata),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_result   (mem_result),
      .mem_zero     (mem_zero),
      .mem_pc       (mem_pc),
      .mem_wen      (mem_wen),
      .mem_wreg     (mem_wreg),
      .mem_mem_op   (mem_mem_op),
      .mem_sdata    (mem_sdata),
      .mem_exc      (mem_exc),
      .mem_exc_code (mem_exc_code),
      .mem_badvaddr (mem_badvaddr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] res, input logic [2:0] op,
                        input logic wen, input logic over, input logic trap,
                        input logic [31:0] pc);
      ex_valid   = v;
      ex_result  = res;
      ex_mem_op  = op;
      ex_wen     = wen;
      ex_over    = over;
      ex_trap_ov = trap;
      ex_pc      = pc;
      ex_zero    = (res == 32'd0);
      ex_wreg    = res[4:0];
      ex_sdata   = res ^ 32'hA5A5_0000;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      mem_ready = 1'b0;
      drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      #2;
      chk("reset_mem_valid", mem_valid, 0);
      chk("reset_ex_ready", ex_ready, 1);
      chk("reset_mem_result", mem_result, 0);
      chk("reset_mem_exc", mem_exc, 0);
      tick();
      tick();
      rst = 1'b0;

      // Continuous stream of addu results 1..8
      mem_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 32'(i), 3'd0, 1'b1, 1'b0, 1'b0, 32'h0040_0000 + 32'(4 * i));
         tick();
         chk("stream_valid", mem_valid, 1);
         chk("stream_result", mem_result, i);
         chk("stream_ex_ready", ex_ready, 1);
      end
      chk("stream_pc", mem_pc, 32'h0040_0020);
      chk("stream_wreg", mem_wreg, 5'd8);
      chk("stream_sdata", mem_sdata, 32'hA5A5_0008);
      chk("stream_wen", mem_wen, 1);
      drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      chk("stream_drained", mem_valid, 0);

      // Backpressure: A, B accepted, C stalled by ex_ready
      mem_ready = 1'b0;
      drive(1'b1, 32'h10, 3'd0, 1'b1, 1'b0, 1'b0, 32'h100);
      tick();
      chk("bp_a_result", mem_result, 32'h10);
      chk("bp_a_ex_ready", ex_ready, 1);
      drive(1'b1, 32'h11, 3'd0, 1'b1, 1'b0, 1'b0, 32'h104);
      tick();
      chk("bp_full_ex_ready", ex_ready, 0);
      chk("bp_hold_result_1", mem_result, 32'h10);
      chk("bp_hold_pc_1", mem_pc, 32'h100);
      drive(1'b1, 32'h12, 3'd0, 1'b1, 1'b0, 1'b0, 32'h108);
      tick();
      chk("bp_hold_result_2", mem_result, 32'h10);
      chk("bp_hold_ex_ready", ex_ready, 0);
      chk("bp_hold_valid", mem_valid, 1);
      mem_ready = 1'b1;
      tick();
      chk("bp_b_result", mem_result, 32'h11);
      chk("bp_b_ex_ready", ex_ready, 1);
      tick();
      chk("bp_c_result", mem_result, 32'h12);
      chk("bp_c_pc", mem_pc, 32'h108);
      drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      chk("bp_drained", mem_valid, 0);

      // Overflow trap, then the same inputs without trap
      drive(1'b1, 32'h7FFF_FFFF, 3'd0, 1'b1, 1'b1, 1'b1, 32'hBFC0_0010);
      tick();
      chk("ov_exc", mem_exc, 1);
      chk("ov_code", mem_exc_code, 5'h0C);
      chk("ov_wen", mem_wen, 0);
      chk("ov_pc", mem_pc, 32'hBFC0_0010);
      chk("ov_result", mem_result, 32'h7FFF_FFFF);
      chk("ov_badvaddr", mem_badvaddr, 0);
      drive(1'b1, 32'h7FFF_FFFF, 3'd0, 1'b1, 1'b1, 1'b0, 32'hBFC0_0010);
      tick();
      chk("notrap_exc", mem_exc, 0);
      chk("notrap_code", mem_exc_code, 0);
      chk("notrap_wen", mem_wen, 1);

      // Misalignment classification
      drive(1'b1, 32'h8000_0002, 3'd3, 1'b1, 1'b0, 1'b0, 32'h200);
      tick();
      chk("lw_exc", mem_exc, 1);
      chk("lw_code", mem_exc_code, 5'h04);
      chk("lw_badvaddr", mem_badvaddr, 32'h8000_0002);
      chk("lw_wen", mem_wen, 0);
      drive(1'b1, 32'h0000_0003, 3'd5, 1'b0, 1'b0, 1'b0, 32'h204);
      tick();
      chk("sh_code", mem_exc_code, 5'h05);
      chk("sh_mem_op", mem_mem_op, 0);
      chk("sh_badvaddr", mem_badvaddr, 32'h3);
      drive(1'b1, 32'h0000_0003, 3'd1, 1'b1, 1'b0, 1'b0, 32'h208);
      tick();
      chk("lb_exc", mem_exc, 0);
      chk("lb_mem_op", mem_mem_op, 3'd1);
      chk("lb_badvaddr", mem_badvaddr, 0);
      drive(1'b1, 32'h0000_0004, 3'd3, 1'b1, 1'b0, 1'b0, 32'h20C);
      tick();
      chk("lw_aligned_exc", mem_exc, 0);
      chk("lw_aligned_op", mem_mem_op, 3'd3);
      drive(1'b1, 32'h0000_0006, 3'd2, 1'b1, 1'b0, 1'b0, 32'h210);
      tick();
      chk("lh_aligned_exc", mem_exc, 0);
      drive(1'b1, 32'h0000_0002, 3'd6, 1'b0, 1'b0, 1'b0, 32'h214);
      tick();
      chk("sw_code", mem_exc_code, 5'h05);
      drive(1'b1, 32'h0000_0002, 3'd3, 1'b1, 1'b1, 1'b1, 32'h218);
      tick();
      chk("prio_code", mem_exc_code, 5'h0C);
      chk("prio_badvaddr", mem_badvaddr, 0);
      drive(1'b1, 32'h0000_0001, 3'd7, 1'b1, 1'b0, 1'b0, 32'h21C);
      tick();
      chk("rsvd_mem_op", mem_mem_op, 0);
      chk("rsvd_exc", mem_exc, 0);
      drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();

      // Flush while FULL with ex_valid high
      mem_ready = 1'b0;
      drive(1'b1, 32'h20, 3'd0, 1'b1, 1'b0, 1'b0, 32'h300);
      tick();
      drive(1'b1, 32'h21, 3'd0, 1'b1, 1'b0, 1'b0, 32'h304);
      tick();
      chk("fl_full_ex_ready", ex_ready, 0);
      flush = 1'b1;
      drive(1'b1, 32'h22, 3'd0, 1'b1, 1'b0, 1'b0, 32'h308);
      tick();
      chk("fl_full_valid", mem_valid, 0);
      chk("fl_full_ex_ready_after", ex_ready, 1);

      // Flush in ONE with a same-cycle accept: the accept is discarded
      flush = 1'b0;
      drive(1'b1, 32'h30, 3'd0, 1'b1, 1'b0, 1'b0, 32'h400);
      tick();
      chk("fl_one_result", mem_result, 32'h30);
      flush = 1'b1;
      drive(1'b1, 32'h31, 3'd0, 1'b1, 1'b0, 1'b0, 32'h404);
      tick();
      chk("fl_one_valid", mem_valid, 0);
      flush = 1'b0;
      drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      chk("fl_one_stays_empty", mem_valid, 0);
      mem_ready = 1'b1;
      drive(1'b1, 32'h40, 3'd0, 1'b1, 1'b0, 1'b0, 32'h500);
      tick();
      chk("fl_next_result", mem_result, 32'h40);
      chk("fl_next_valid", mem_valid, 1);
      drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();

      // Asynchronous reset mid-cycle while FULL
      mem_ready = 1'b0;
      drive(1'b1, 32'h50, 3'd0, 1'b1, 1'b0, 1'b0, 32'h600);
      tick();
      drive(1'b1, 32'h51, 3'd0, 1'b1, 1'b0, 1'b0, 32'h604);
      tick();
      chk("ar_full_ex_ready", ex_ready, 0);
      drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_mem_valid", mem_valid, 0);
      chk("ar_ex_ready", ex_ready, 1);
      chk("ar_mem_result", mem_result, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("ar_after_valid", mem_valid, 0);
      mem_ready = 1'b1;
      drive(1'b1, 32'h60, 3'd0, 1'b1, 1'b0, 1'b0, 32'h700);
      tick();
      chk("ar_restart_result", mem_result, 32'h60);
      drive(1'b0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
